// File: rtl/block_stream_pkg.sv
// ----------------------------------------------------------------------------
// block_stream_pkg
// Shared constants for the begin/end keyword byte stream: ASCII codes of the
// keyword letters and the delimiter, token-type encodings, sequence lengths,
// the token FSM state encoding and a case-folding helper.
// ----------------------------------------------------------------------------
package block_stream_pkg;

    // Lowercase ASCII letters used by the two keywords, plus the delimiter.
    localparam logic [7:0] CH_B     = 8'h62;
    localparam logic [7:0] CH_E     = 8'h65;
    localparam logic [7:0] CH_G     = 8'h67;
    localparam logic [7:0] CH_I     = 8'h69;
    localparam logic [7:0] CH_N     = 8'h6E;
    localparam logic [7:0] CH_D     = 8'h64;
    localparam logic [7:0] CH_SP    = 8'h20;
    // Lowercase minus this offset gives the uppercase letter.
    localparam logic [7:0] CASE_OFS = 8'h20;

    // Token type encodings on tok_type.
    localparam logic TOK_BEGIN = 1'b0;
    localparam logic TOK_END   = 1'b1;

    // Bytes per token, trailing space included.
    localparam int LEN_BEGIN = 6;
    localparam int LEN_END   = 4;

    // Byte index width; must hold LEN_BEGIN-1.
    localparam int IDX_W = 3;

    // Token FSM state encoding.
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_EMIT = 1'b1;

    // Fold a lowercase letter to uppercase; the delimiter is never folded.
    function automatic logic [7:0] apply_case(input logic [7:0] ch,
                                              input logic       upper);
        if (upper && (ch != CH_SP))
            return ch - CASE_OFS;
        return ch;
    endfunction

endpackage

// File: rtl/block_token_tx_if.sv
// ----------------------------------------------------------------------------
// block_token_tx_if
// Token request handshake into block_token_tx.
//   tok_valid : requester has a token this cycle
//   tok_type  : 0 = begin, 1 = end
//   tok_upper : 1 = emit letters in uppercase
//   tok_ready : transmitter can accept a token this cycle
// master = token source, slave = block_token_tx.
// ----------------------------------------------------------------------------
interface block_token_tx_if;

    logic tok_valid;
    logic tok_type;
    logic tok_upper;
    logic tok_ready;

    modport master (
        output tok_valid,
        output tok_type,
        output tok_upper,
        input  tok_ready
    );

    modport slave (
        input  tok_valid,
        input  tok_type,
        input  tok_upper,
        output tok_ready
    );

endinterface

// File: rtl/block_token_rom.sv
// ----------------------------------------------------------------------------
// block_token_rom
// Combinational keyword lookup: maps (token type, byte index, case) to the
// ASCII byte of that position and flags the trailing delimiter.
//   i_type  : token type (TOK_BEGIN / TOK_END)
//   i_idx   : byte position within the token
//   i_upper : 1 = uppercase letters
//   o_byte  : ASCII byte for this position
//   o_last  : this position is the trailing space
// ----------------------------------------------------------------------------
module block_token_rom
    import block_stream_pkg::*;
(
    input  logic             i_type,
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_upper,
    output logic [7:0]       o_byte,
    output logic             o_last
);

    logic [7:0] w_ch;

    always_comb begin
        w_ch   = CH_SP;
        o_last = 1'b0;
        if (i_type == TOK_BEGIN) begin
            case (i_idx)
                3'd0:    w_ch = CH_B;
                3'd1:    w_ch = CH_E;
                3'd2:    w_ch = CH_G;
                3'd3:    w_ch = CH_I;
                3'd4:    w_ch = CH_N;
                default: w_ch = CH_SP;
            endcase
            // Any out-of-range index is treated as the delimiter so the FSM
            // always finds its way back to IDLE.
            o_last = (i_idx >= IDX_W'(LEN_BEGIN - 1));
        end else begin
            case (i_idx)
                3'd0:    w_ch = CH_E;
                3'd1:    w_ch = CH_N;
                3'd2:    w_ch = CH_D;
                default: w_ch = CH_SP;
            endcase
            o_last = (i_idx >= IDX_W'(LEN_END - 1));
        end
    end

    assign o_byte = apply_case(w_ch, i_upper);

endmodule

// File: rtl/block_token_tx.sv
// ----------------------------------------------------------------------------
// block_token_tx
// Serialises begin/end keyword tokens into an ASCII byte stream, one byte per
// clock with a trailing space, and tracks the resulting nesting depth.
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset
//   tok       : token handshake (slave side of block_token_tx_if)
//   out       : ASCII byte to the checker
//   out_valid : out carries a stream byte this cycle
//   depth     : current nesting depth
//   mismatch  : sticky, an end was emitted at depth 0
//   overflow  : sticky, a begin was emitted at maximum depth
//   balanced  : depth == 0 with neither sticky flag set
// ----------------------------------------------------------------------------
module block_token_tx
    import block_stream_pkg::*;
#(
    parameter int DEPTH_W = 8
)(
    input  logic               clk,
    input  logic               reset,
    block_token_tx_if.slave    tok,
    output logic [7:0]         out,
    output logic               out_valid,
    output logic [DEPTH_W-1:0] depth,
    output logic               mismatch,
    output logic               overflow,
    output logic               balanced
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_type;
    logic               r_upper;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_mismatch;
    logic               r_overflow;

    logic [7:0]         w_rom_byte;
    logic               w_rom_last;
    logic               w_emit;
    logic               w_last;
    logic               w_accept;

    block_token_rom u_rom (
        .i_type  (r_type),
        .i_idx   (r_idx),
        .i_upper (r_upper),
        .o_byte  (w_rom_byte),
        .o_last  (w_rom_last)
    );

    assign w_emit = (r_state == ST_EMIT);
    assign w_last = w_emit && w_rom_last;

    // Ready in IDLE and on the delimiter cycle, which is what allows
    // back-to-back tokens without a gap. Gated by reset so the requester
    // sees not-ready while reset is held.
    assign tok.tok_ready = reset && (!w_emit || w_last);
    assign w_accept      = tok.tok_valid && tok.tok_ready;

    // The byte comes straight from the registered index/type/case, so it
    // drops to zero the moment reset forces the state back to IDLE.
    assign out       = w_emit ? w_rom_byte : 8'h00;
    assign out_valid = w_emit;

    assign depth    = r_depth;
    assign mismatch = r_mismatch;
    assign overflow = r_overflow;
    assign balanced = (r_depth == '0) && !r_mismatch && !r_overflow;

    // Token FSM: accept, then walk the byte index until the delimiter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_type  <= TOK_BEGIN;
            r_upper <= 1'b0;
        end else if (w_accept) begin
            r_state <= ST_EMIT;
            r_idx   <= '0;
            r_type  <= tok.tok_type;
            r_upper <= tok.tok_upper;
        end else if (w_last) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else if (w_emit) begin
            r_idx   <= r_idx + 1'b1;
        end
    end

    // Depth bookkeeping happens on the delimiter cycle only, so a token cut
    // short by reset never touches the counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_depth    <= '0;
            r_mismatch <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_last) begin
            if (r_type == TOK_BEGIN) begin
                if (r_depth == DEPTH_MAX)
                    r_overflow <= 1'b1;
                else
                    r_depth <= r_depth + 1'b1;
            end else begin
                if (r_depth == '0)
                    r_mismatch <= 1'b1;
                else
                    r_depth <= r_depth - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_block_token_tx.sv
module tb_block_token_tx;

    logic       clk;
    logic       reset;

    block_token_tx_if tif ();
    block_token_tx_if tif2 ();

    logic [7:0] out;
    logic       out_valid;
    logic [7:0] depth;
    logic       mismatch;
    logic       overflow;
    logic       balanced;

    logic [7:0] out2;
    logic       out_valid2;
    logic [1:0] depth2;
    logic       mismatch2;
    logic       overflow2;
    logic       balanced2;

    int errors = 0;
    int checks = 0;

    block_token_tx #(.DEPTH_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .tok       (tif),
        .out       (out),
        .out_valid (out_valid),
        .depth     (depth),
        .mismatch  (mismatch),
        .overflow  (overflow),
        .balanced  (balanced)
    );

    block_token_tx #(.DEPTH_W(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .tok       (tif2),
        .out       (out2),
        .out_valid (out_valid2),
        .depth     (depth2),
        .mismatch  (mismatch2),
        .overflow  (overflow2),
        .balanced  (balanced2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a token for one edge (transmitter must be ready), leave the
    // bench 1 time unit after that edge with the first byte on out.
    task automatic issue(input logic t, input logic u);
        tif.tok_valid = 1'b1;
        tif.tok_type  = t;
        tif.tok_upper = u;
        @(posedge clk); #1;
        tif.tok_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (tif.tok_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", tif.tok_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out !== 8'h00) begin errors++; $display("FAIL rst_out: got %h want 00", out); end
        checks++; if (depth !== 8'd0) begin errors++; $display("FAIL rst_depth: got %0d want 0", depth); end
        checks++; if (mismatch !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rst_flags: got mm=%b ov=%b want 0 0", mismatch, overflow); end
        checks++; if (balanced !== 1'b1) begin errors++; $display("FAIL rst_balanced: got %b want 1", balanced); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (tif.tok_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", tif.tok_ready); end
    endtask

    task automatic test_begin();
        logic [7:0] exp [6] = '{8'h62, 8'h65, 8'h67, 8'h69, 8'h6E, 8'h20};
        issue(1'b0, 1'b0);
        // Changing the inputs after acceptance must not alter the token.
        tif.tok_type  = 1'b1;
        tif.tok_upper = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (out !== exp[i]) begin errors++; $display("FAIL begin_byte%0d: got %h want %h", i, out, exp[i]); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL begin_valid%0d: got %b want 1", i, out_valid); end
            checks++; if (tif.tok_ready !== (i == 5)) begin errors++; $display("FAIL begin_ready%0d: got %b want %b", i, tif.tok_ready, (i == 5)); end
            if (i < 5) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        checks++; if (depth !== 8'd1) begin errors++; $display("FAIL begin_depth: got %0d want 1", depth); end
        checks++; if (balanced !== 1'b0) begin errors++; $display("FAIL begin_balanced: got %b want 0", balanced); end
        checks++; if (out_valid !== 1'b0 || out !== 8'h00) begin errors++; $display("FAIL begin_idle: got v=%b out=%h want 0 00", out_valid, out); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [10] = '{8'h62, 8'h65, 8'h67, 8'h69, 8'h6E, 8'h20,
                                 8'h65, 8'h6E, 8'h64, 8'h20};
        pulse_reset();
        tif.tok_valid = 1'b1;
        tif.tok_type  = 1'b0;
        tif.tok_upper = 1'b0;
        @(posedge clk); #1;
        tif.tok_type = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (out !== exp[i] || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_byte%0d: got v=%b %h want 1 %h", i, out_valid, out, exp[i]); end
            if (i == 5) begin
                checks++; if (tif.tok_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_last: got %b want 1", tif.tok_ready); end
                checks++; if (depth !== 8'd0) begin errors++; $display("FAIL b2b_depth_early: got %0d want 0", depth); end
            end
            if (i == 6) begin
                tif.tok_valid = 1'b0;
                checks++; if (depth !== 8'd1) begin errors++; $display("FAIL b2b_depth_mid: got %0d want 1", depth); end
            end
            if (i < 9) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        checks++; if (depth !== 8'd0) begin errors++; $display("FAIL b2b_depth: got %0d want 0", depth); end
        checks++; if (balanced !== 1'b1) begin errors++; $display("FAIL b2b_balanced: got %b want 1", balanced); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", out_valid); end
    endtask

    task automatic test_mismatch();
        logic [7:0] exp [4] = '{8'h65, 8'h6E, 8'h64, 8'h20};
        issue(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (out !== exp[i] || out_valid !== 1'b1) begin errors++; $display("FAIL end_byte%0d: got v=%b %h want 1 %h", i, out_valid, out, exp[i]); end
            if (i < 3) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL mm_flag: got %b want 1", mismatch); end
        checks++; if (depth !== 8'd0) begin errors++; $display("FAIL mm_depth: got %0d want 0", depth); end
        checks++; if (balanced !== 1'b0) begin errors++; $display("FAIL mm_balanced: got %b want 0", balanced); end
        issue(1'b0, 1'b0);
        repeat (6) begin @(posedge clk); #1; end
        checks++; if (depth !== 8'd1) begin errors++; $display("FAIL mm_pair_depth1: got %0d want 1", depth); end
        issue(1'b1, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        checks++; if (depth !== 8'd0) begin errors++; $display("FAIL mm_pair_depth0: got %0d want 0", depth); end
        checks++; if (mismatch !== 1'b1 || balanced !== 1'b0) begin errors++; $display("FAIL mm_sticky: got mm=%b bal=%b want 1 0", mismatch, balanced); end
    endtask

    task automatic test_upper();
        logic [7:0] exp [6] = '{8'h42, 8'h45, 8'h47, 8'h49, 8'h4E, 8'h20};
        pulse_reset();
        issue(1'b0, 1'b1);
        tif.tok_upper = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++; if (out !== exp[i] || out_valid !== 1'b1) begin errors++; $display("FAIL upper_byte%0d: got v=%b %h want 1 %h", i, out_valid, out, exp[i]); end
            if (i < 5) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        checks++; if (depth !== 8'd1) begin errors++; $display("FAIL upper_depth: got %0d want 1", depth); end
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (out !== 8'h67) begin errors++; $display("FAIL rmid_third: got %h want 67", out); end
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out !== 8'h00) begin errors++; $display("FAIL rmid_async_out: got v=%b %h want 0 00", out_valid, out); end
        checks++; if (tif.tok_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %b want 0", tif.tok_ready); end
        checks++; if (depth !== 8'd0) begin errors++; $display("FAIL rmid_async_depth: got %0d want 0", depth); end
        #3;
        reset = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        checks++; if (depth !== 8'd0 || balanced !== 1'b1) begin errors++; $display("FAIL rmid_after: got depth=%0d bal=%b want 0 1", depth, balanced); end
        checks++; if (out_valid !== 1'b0 || tif.tok_ready !== 1'b1) begin errors++; $display("FAIL rmid_idle: got v=%b rdy=%b want 0 1", out_valid, tif.tok_ready); end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 4; k++) begin
            tif2.tok_valid = 1'b1;
            tif2.tok_type  = 1'b0;
            tif2.tok_upper = 1'b0;
            @(posedge clk); #1;
            tif2.tok_valid = 1'b0;
            repeat (6) begin @(posedge clk); #1; end
            checks++; if (depth2 !== ((k <= 3) ? 2'(k) : 2'd3)) begin errors++; $display("FAIL ovf_depth%0d: got %0d want %0d", k, depth2, (k <= 3) ? k : 3); end
            checks++; if (overflow2 !== (k == 4)) begin errors++; $display("FAIL ovf_flag%0d: got %b want %b", k, overflow2, (k == 4)); end
        end
        checks++; if (balanced2 !== 1'b0 || mismatch2 !== 1'b0) begin errors++; $display("FAIL ovf_status: got bal=%b mm=%b want 0 0", balanced2, mismatch2); end
    endtask

    initial begin
        reset          = 1'b0;
        tif.tok_valid  = 1'b0;
        tif.tok_type   = 1'b0;
        tif.tok_upper  = 1'b0;
        tif2.tok_valid = 1'b0;
        tif2.tok_type  = 1'b0;
        tif2.tok_upper = 1'b0;
        test_reset();
        test_begin();
        test_back_to_back();
        test_mismatch();
        test_upper();
        test_reset_mid();
        test_overflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/block_token_tx.md
Name: block_token_tx

Overview:
- Transmitter side of the begin/end keyword byte stream consumed by BlockChecker.
- Accepts keyword tokens (begin / end) over a valid/ready handshake and serialises each as ASCII bytes, one per clock, followed by one space delimiter.
- Tracks its own nesting depth so the generator's view of balance can be compared against the checker's result.
- Sits in front of the checker in stimulus and self-test paths.

Parameters:
- DEPTH_W, 8: width of the nesting-depth counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- tok_valid  input  1  token request valid.
- tok_type  input  1  0 = "begin", 1 = "end".
- tok_upper  input  1  1 = emit letters uppercase; latched with the token.
- tok_ready  output  1  token can be accepted this cycle.
- out  output  8  ASCII byte to checker.
- out_valid  output  1  out carries a stream byte this cycle.
- depth  output  DEPTH_W  current nesting depth.
- mismatch  output  1  sticky: an "end" was emitted at depth 0.
- overflow  output  1  sticky: a "begin" was emitted at maximum depth.
- balanced  output  1  depth==0 && !mismatch && !overflow.

Behaviour:
- Reset (reset==0, async): state IDLE, out=8'h00, out_valid=0, tok_ready=0 during reset, depth=0, mismatch=0, overflow=0, balanced=1. Effective immediately, mid-token included; a partially emitted token is abandoned and no depth update occurs.
- FSM states: IDLE, EMIT.
- IDLE:
  - tok_ready=1, out_valid=0, out=8'h00.
  - Acceptance on tok_valid&&tok_ready latches tok_type and tok_upper, clears the index to 0, and moves to EMIT.
- EMIT:
  - Drives one registered byte per cycle; out_valid=1.
  - The first byte appears the cycle after acceptance (latency 1).
  - begin sequence: 'b','e','g','i','n',' ' (6 bytes). end sequence: 'e','n','d',' ' (4 bytes).
  - Uppercase: letters minus 8'h20. The space is always 8'h20.
  - No downstream backpressure; bytes are never stalled.
- Last byte (the trailing space):
  - tok_ready=1 in that cycle.
  - If a new token is accepted there, EMIT restarts at index 0 next cycle. This is back-to-back operation with no gap byte.
  - Otherwise the FSM returns to IDLE.
  - tok_ready=0 on all other EMIT cycles.
- Depth update: registered in the cycle the trailing space is driven, visible the following cycle.
  - begin: if depth==2^DEPTH_W-1, set overflow and hold depth; else depth+1.
  - end: if depth==0, set mismatch and hold depth; else depth-1.
- mismatch and overflow clear only by reset.
- balanced is combinational from registers.
- tok_type and tok_upper are ignored when not accepted; changes mid-token have no effect.

Decomposition:
- Shared package block_stream_pkg holds:
  - ASCII constants CH_B, CH_E, CH_G, CH_I, CH_N, CH_D, CH_SP, and CASE_OFS=8'h20.
  - Token-type constants TOK_BEGIN=1'b0, TOK_END=1'b1.
  - Sequence lengths LEN_BEGIN=6, LEN_END=4.
  - FSM state typedef.
- One sub-module, block_token_rom: combinational (type, index, upper) -> byte and last flag.
- FSM, handshake and depth counter stay in the top module.

Test Plan:
- Reset, then begin: out sequence 62,65,67,69,6E,20 (hex) on 6 consecutive cycles starting one cycle after acceptance. depth=1, balanced=0 afterwards.
- begin, then end back-to-back (tok_valid held through the last byte): stream "begin end " with no gap cycle. depth returns 0, balanced=1.
- end at depth 0: bytes 65,6E,64,20. mismatch=1, depth=0, balanced=0. A subsequent begin/end pair leaves mismatch=1 and balanced=0.
- tok_upper=1 begin: 42,45,47,49,4E,20.
- reset driven low on the 3rd byte of begin: out_valid=0 and out=00 immediately without a clock edge; after release depth=0 and the FSM is in IDLE.
- DEPTH_W=2, four begins: depth reaches 3 and holds. overflow=1 after the 4th trailing space.
